// File: rtl/pac_man_move_check.sv
// Validates each candidate Pac-Man move against grid edges and maze walls, eats pellets, keeps score.
// Optional frightened-mode counter is enabled by defining POWER_PELLET_EN.
module pac_man_move_check #(
  parameter int GRID_W        = 32,
  parameter int ADDR_W        = 10,
  parameter int MAZE_LAT      = 1,
  parameter int TOTAL_PELLETS = 240,
  parameter int SCORE_W       = 16,
  parameter int POWER_TICKS   = 300
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_tick,
  input  logic [ADDR_W-1:0]  curr_block,
  input  logic [ADDR_W-1:0]  temp_next,
  output logic [ADDR_W-1:0]  maze_addr,
  output logic               maze_rd,
  input  logic [1:0]         maze_rdata,
  output logic               maze_wr,
  output logic               can_move,
  output logic               move_blocked,
  output logic               busy,
  output logic               tick_dropped,
  output logic               pellet_eaten,
  output logic [SCORE_W-1:0] score,
  output logic [ADDR_W-1:0]  pellets_left,
  output logic               level_clear,
  output logic               power_active
);

  // state  | meaning
  // IDLE   | waiting for move_tick; latches cur/cand
  // READ   | geometry check; issues maze read or rejects the move
  // WAIT   | counts maze RAM latency, captures tile code on the last cycle
  // DECIDE | accept/reject on tile code; eats pellet if present
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_DECIDE} state_t;

  localparam int ROW_SH = $clog2(GRID_W);
  localparam int LAT_W  = $clog2(MAZE_LAT + 1);
  localparam logic [ADDR_W-1:0] GRID_A     = ADDR_W'(GRID_W);
  localparam logic [ADDR_W-1:0] BOTTOM_ROW = ADDR_W'(GRID_W * (GRID_W - 1));
  localparam logic [SCORE_W:0]  PELLET_PTS = (SCORE_W+1)'(10);
  localparam logic [SCORE_W:0]  POWER_PTS  = (SCORE_W+1)'(50);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cand, cur;
  logic [ADDR_W-1:0]   addr_hold;
  logic [LAT_W-1:0]    lat_cnt;
  logic [1:0]          rdata_q;
  logic [SCORE_W-1:0]  score_q;
  logic [ADDR_W-1:0]   pellets_q;
  logic [SCORE_W:0]    score_sum;
  logic                geom_ok;
  logic                same_row;
  logic                horiz, up_ok, down_ok;

  // Row-wrap and top/bottom edges are the only illegal single-step moves.
  always_comb begin
    same_row = (cand >> ROW_SH) == (cur >> ROW_SH);
    horiz    = (cand == cur + ADDR_W'(1)) || (cand == cur - ADDR_W'(1));
    up_ok    = (cand == cur - GRID_A) && (cur >= GRID_A);
    down_ok  = (cand == cur + GRID_A) && (cur < BOTTOM_ROW);
    geom_ok  = (horiz && same_row) || up_ok || down_ok;
  end

  always_comb begin
    state_nxt    = state;
    maze_rd      = 1'b0;
    maze_wr      = 1'b0;
    can_move     = 1'b0;
    move_blocked = 1'b0;
    case (state)
      S_IDLE: begin
        if (move_tick && (temp_next != curr_block)) state_nxt = S_READ;
      end
      S_READ: begin
        if (geom_ok) begin
          maze_rd   = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          move_blocked = 1'b1;
          state_nxt    = S_IDLE;
        end
      end
      S_WAIT: begin
        if (lat_cnt == '0) state_nxt = S_DECIDE;
      end
      S_DECIDE: begin
        if (rdata_q == 2'b01) begin
          move_blocked = 1'b1;
        end else begin
          can_move = 1'b1;
          maze_wr  = rdata_q[1];
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign maze_addr    = (maze_rd || maze_wr) ? cand : addr_hold;
  assign pellet_eaten = maze_wr;
  assign busy         = (state != S_IDLE);
  assign tick_dropped = busy && move_tick;
  assign score        = score_q;
  assign pellets_left = pellets_q;
  assign level_clear  = (pellets_q == '0);
  assign score_sum    = {1'b0, score_q} + (rdata_q[0] ? POWER_PTS : PELLET_PTS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cand      <= '0;
      cur       <= '0;
      addr_hold <= '0;
      lat_cnt   <= '0;
      rdata_q   <= 2'b00;
      score_q   <= '0;
      pellets_q <= ADDR_W'(TOTAL_PELLETS);
    end else begin
      state     <= state_nxt;
      addr_hold <= maze_addr;
      if (state == S_IDLE && move_tick) begin
        cand <= temp_next;
        cur  <= curr_block;
      end
      if (state == S_READ) lat_cnt <= LAT_W'(MAZE_LAT - 1);
      if (state == S_WAIT) begin
        if (lat_cnt == '0) rdata_q <= maze_rdata;
        else               lat_cnt <= lat_cnt - LAT_W'(1);
      end
      if (maze_wr) begin
        score_q <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        if (pellets_q != '0) pellets_q <= pellets_q - ADDR_W'(1);
      end
    end
  end

`ifdef POWER_PELLET_EN
  localparam int POW_W = $clog2(POWER_TICKS + 1);
  logic [POW_W-1:0] pow_cnt;

  // A fresh power pellet wins over the tick decrement in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pow_cnt <= '0;
    end else if (maze_wr && rdata_q == 2'b11) begin
      pow_cnt <= POW_W'(POWER_TICKS);
    end else if (move_tick && pow_cnt != '0) begin
      pow_cnt <= pow_cnt - POW_W'(1);
    end
  end

  assign power_active = (pow_cnt != '0);
`else
  assign power_active = 1'b0;
`endif

endmodule

// File: tb/tb_pac_man_move_check.sv
// Scoreboard bench for pac_man_move_check with a behavioural 1-cycle maze RAM.
module tb_pac_man_move_check;

  logic        clk, reset, move_tick;
  logic [9:0]  curr_block, temp_next;
  logic [9:0]  maze_addr, pellets_left, maze_addr_1, pellets_left_1;
  logic        maze_rd, maze_wr, can_move, move_blocked, busy, tick_dropped;
  logic        pellet_eaten, level_clear, power_active;
  logic        maze_rd_1, maze_wr_1, can_move_1, move_blocked_1, busy_1, tick_dropped_1;
  logic        pellet_eaten_1, level_clear_1, power_active_1;
  logic [1:0]  maze_rdata;
  logic [15:0] score, score_1;

  pac_man_move_check u_dut (
    .clk(clk), .reset(reset), .move_tick(move_tick), .curr_block(curr_block),
    .temp_next(temp_next), .maze_addr(maze_addr), .maze_rd(maze_rd),
    .maze_rdata(maze_rdata), .maze_wr(maze_wr), .can_move(can_move),
    .move_blocked(move_blocked), .busy(busy), .tick_dropped(tick_dropped),
    .pellet_eaten(pellet_eaten), .score(score), .pellets_left(pellets_left),
    .level_clear(level_clear), .power_active(power_active));

  pac_man_move_check #(.TOTAL_PELLETS(1)) u_dut1 (
    .clk(clk), .reset(reset), .move_tick(move_tick), .curr_block(curr_block),
    .temp_next(temp_next), .maze_addr(maze_addr_1), .maze_rd(maze_rd_1),
    .maze_rdata(maze_rdata), .maze_wr(maze_wr_1), .can_move(can_move_1),
    .move_blocked(move_blocked_1), .busy(busy_1), .tick_dropped(tick_dropped_1),
    .pellet_eaten(pellet_eaten_1), .score(score_1), .pellets_left(pellets_left_1),
    .level_clear(level_clear_1), .power_active(power_active_1));

  typedef struct {
    int         kind;   // 2 = can_move, 1 = move_blocked
    int         cyc;
    logic       wr;
    logic [9:0] addr;
  } sb_t;

  sb_t        sb[$];
  sb_t        mon_e;
  logic [1:0] maze [1024];
  int         cyc = 0;
  int         rd_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_score = 0;
  int         exp_pellets = 240;
  int         exp_p1 = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (maze_rd) maze_rdata <= maze[maze_addr];
    if (maze_wr) maze[maze_addr] <= 2'b00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit geo_model(input int cur, input int cand);
    int rc, cc, rn, cn;
    rc = cur / 32; cc = cur % 32;
    rn = cand / 32; cn = cand % 32;
    return (rn == rc && (cn == cc + 1 || cn == cc - 1)) ||
           (cn == cc && (rn == rc + 1 || rn == rc - 1));
  endfunction

  always @(negedge clk) begin
    if (maze_rd) rd_cnt++;
    if (can_move || move_blocked) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {30'd0, can_move, move_blocked}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result_kind", {30'd0, can_move, move_blocked}, mon_e.kind);
        check("result_cycle", cyc, mon_e.cyc);
        check("maze_wr", maze_wr, mon_e.wr);
        check("pellet_eaten", pellet_eaten, mon_e.wr);
        if (mon_e.wr) check("wr_addr", maze_addr, mon_e.addr);
      end
    end else if (maze_wr || pellet_eaten) begin
      check("stray_write", {30'd0, maze_wr, pellet_eaten}, 32'd0);
    end
  end

  task automatic do_move(input logic [9:0] cur, input logic [9:0] cand, input bit inject);
    sb_t        e;
    int         rd0;
    bit         geo;
    logic [1:0] tile;
    rd0  = rd_cnt;
    geo  = geo_model(cur, cand);
    tile = maze[cand];
    @(negedge clk);
    curr_block = cur; temp_next = cand; move_tick = 1'b1;
    if (cand != cur) begin
      e.cyc  = cyc + (geo ? 3 : 1);
      e.addr = cand;
      e.wr   = geo && tile[1];
      e.kind = (!geo || tile == 2'b01) ? 1 : 2;
      sb.push_back(e);
      if (e.wr) begin
        exp_score = exp_score + (tile[0] ? 50 : 10);
        if (exp_score > 65535) exp_score = 65535;
        if (exp_pellets > 0) exp_pellets--;
        if (exp_p1 > 0) exp_p1--;
      end
    end
    @(negedge clk);
    move_tick = 1'b0;
    @(negedge clk);
    if (inject) begin
      move_tick = 1'b1; temp_next = cand + 10'd1; curr_block = cand;
      #1 check("tick_dropped", tick_dropped, 1'b1);
    end
    @(negedge clk);
    move_tick = 1'b0;
    repeat (4) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    sb.delete();
    check("rd_count", rd_cnt - rd0, (cand != cur && geo) ? 1 : 0);
    check("score", score, exp_score);
    check("pellets_left", pellets_left, exp_pellets);
    check("level_clear", level_clear, exp_pellets == 0);
    check("busy_idle", busy, 1'b0);
    check("pellets_left_1", pellets_left_1, exp_p1);
    check("level_clear_1", level_clear_1, exp_p1 == 0);
  endtask

  task automatic idle_tick();
    @(negedge clk);
    curr_block = 10'd50; temp_next = 10'd50; move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) maze[i] = 2'b00;
    maze_rdata = 2'b00;
    reset = 1'b0; move_tick = 1'b0; curr_block = '0; temp_next = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_score", score, 0);
    check("rst_pellets", pellets_left, 240);
    check("rst_level_clear", level_clear, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_power", power_active, 1'b0);
    check("rst_can_move", can_move, 1'b0);
    check("rst_maze_rd", maze_rd, 1'b0);

    maze[132] = 2'b01;
    do_move(10'd100, 10'd101, 0);   // open tile
    do_move(10'd100, 10'd132, 0);   // wall below
    do_move(10'd31,  10'd32,  0);   // row-edge wrap
    do_move(10'd5,   10'd997, 0);   // top underflow
    do_move(10'd1000, 10'd8,  0);   // bottom overflow
    do_move(10'd1023, 10'd0,  0);   // +1 wrapping past last tile
    do_move(10'd100, 10'd102, 0);   // illegal delta
    do_move(10'd100, 10'd100, 0);   // no move
    maze[101] = 2'b10;
    do_move(10'd100, 10'd101, 0);   // pellet
    maze[102] = 2'b11;
    do_move(10'd101, 10'd102, 0);   // power pellet
`ifndef POWER_PELLET_EN
    check("power_off", power_active, 1'b0);
`endif
    do_move(10'd102, 10'd101, 0);   // -1, already eaten
    do_move(10'd133, 10'd101, 0);   // -GRID_W
    maze[500] = 2'b10;
    do_move(10'd499, 10'd500, 1);   // tick dropped while busy

    maze[400] = 2'b10;
    @(negedge clk);
    curr_block = 10'd399; temp_next = 10'd400; move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_can_move", can_move, 1'b0);
    check("mrst_maze_wr", maze_wr, 1'b0);
    check("mrst_score", score, 0);
    check("mrst_pellets", pellets_left, 240);
    check("mrst_power", power_active, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("mrst_tile_kept", maze[400], 2'b10);
    exp_score = 0; exp_pellets = 240; exp_p1 = 1;

    for (int i = 0; i < 1320; i++) begin
      if (i % 2 == 0) begin
        maze[201] = 2'b11;
        do_move(10'd200, 10'd201, 0);
      end else begin
        maze[200] = 2'b11;
        do_move(10'd201, 10'd200, 0);
      end
    end
    check("score_sat", score, 16'hFFFF);
    check("pellets_floor", pellets_left, 0);

`ifdef POWER_PELLET_EN
    repeat (300) idle_tick();
    check("power_expired_pre", power_active, 1'b0);
    maze[302] = 2'b11;
    do_move(10'd301, 10'd302, 0);
    check("power_on", power_active, 1'b1);
    repeat (299) idle_tick();
    check("power_299", power_active, 1'b1);
    idle_tick();
    check("power_300", power_active, 1'b0);
    maze[303] = 2'b11;
    maze[304] = 2'b11;
    do_move(10'd302, 10'd303, 0);
    repeat (149) idle_tick();
    do_move(10'd303, 10'd304, 0);
    repeat (299) idle_tick();
    check("power_449", power_active, 1'b1);
    idle_tick();
    check("power_450", power_active, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
